// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_stream serialiser.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAR
    } state_t;

    function automatic int beats_f(input int width, input int lanes);
        return width / lanes;
    endfunction

    // A single-beat word still needs a 1-bit counter.
    function automatic int cnt_w_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/piso_beat_mux.sv
// Combinational selection of lane-group idx from a word, MSB- or LSB-first.
module piso_beat_mux
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LANES     = 1,
    parameter int LSB_FIRST = 0,
    parameter int IW        = 2
) (
    input  logic [WIDTH-1:0] word,
    input  logic [IW-1:0]    idx,
    output logic [LANES-1:0] beat
);

    localparam int BEATS = beats_f(WIDTH, LANES);

    // Out-of-range indices yield zero.
    always_comb begin
        beat = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (idx == IW'(k)) begin
                if (LSB_FIRST != 0)
                    beat = word[k*LANES +: LANES];
                else
                    beat = word[WIDTH-1-k*LANES -: LANES];
            end
        end
    end

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serialiser with valid/ready on both sides.
// Optional even-parity trailer beat enabled by defining PISO_PARITY_EN.
//
// state | meaning
// IDLE  | no word held, d_ready=1
// SHIFT | emitting data beat idx (0..BEATS-1)
// PAR   | emitting parity beat (PISO_PARITY_EN only)
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LANES     = 1,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
    output logic             d_ready,
    output logic [LANES-1:0] d_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int BEATS = beats_f(WIDTH, LANES);
    localparam int IW    = cnt_w_f(BEATS);
    localparam logic [IW-1:0] LAST = IW'(BEATS - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_inc;
    logic [WIDTH-1:0] sel_word;
    logic [IW-1:0]    sel_idx;
    logic [LANES-1:0] sel_beat;
    logic             accept;
    logic             advance;
    logic             last;

    assign last    = (idx == LAST);
    assign idx_inc = idx + 1'b1;
    assign accept  = d_valid && d_ready;
    assign advance = out_valid && out_ready;
    assign busy    = out_valid;

    always_comb begin
        d_ready = 1'b0;
        if (!reset) begin
`ifdef PISO_PARITY_EN
            d_ready = (state == IDLE) || (state == PAR && out_ready);
`else
            d_ready = (state == IDLE) || (state == SHIFT && last && out_ready);
`endif
        end
    end

    // One mux serves both the fresh word (beat 0) and the next beat of the held word.
    assign sel_word = accept ? d_in : shreg;
    assign sel_idx  = accept ? '0 : idx_inc;

    piso_beat_mux #(
        .WIDTH     (WIDTH),
        .LANES     (LANES),
        .LSB_FIRST (LSB_FIRST),
        .IW        (IW)
    ) u_beat_mux (
        .word (sel_word),
        .idx  (sel_idx),
        .beat (sel_beat)
    );

`ifdef PISO_PARITY_EN
    logic [LANES-1:0] par_beat;
    always_comb begin
        par_beat    = '0;
        par_beat[0] = ^shreg;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            d_out       <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else if (accept) begin
            state       <= SHIFT;
            shreg       <= d_in;
            idx         <= '0;
            d_out       <= sel_beat;
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
`ifdef PISO_PARITY_EN
            frame_end   <= 1'b0;
`else
            frame_end   <= (BEATS == 1);
`endif
        end else if (advance) begin
            case (state)
                SHIFT: begin
                    frame_start <= 1'b0;
                    if (!last) begin
                        idx       <= idx_inc;
                        d_out     <= sel_beat;
`ifdef PISO_PARITY_EN
                        frame_end <= 1'b0;
`else
                        frame_end <= (idx_inc == LAST);
`endif
                    end else begin
`ifdef PISO_PARITY_EN
                        state     <= PAR;
                        d_out     <= par_beat;
                        frame_end <= 1'b1;
`else
                        state     <= IDLE;
                        d_out     <= '0;
                        out_valid <= 1'b0;
                        frame_end <= 1'b0;
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    d_out       <= '0;
                    out_valid   <= 1'b0;
                    frame_start <= 1'b0;
                    frame_end   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out serialiser; successor to the fixed 4-bit load/shift PISO.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it as WIDTH/LANES beats of LANES bits.
- Supports downstream backpressure, selectable bit order, and back-to-back words with no idle beat.
- Sits between parallel datapath logic and serial link or line-driver logic.

Parameters:
- WIDTH, 4, parallel word width in bits; must be ≥2 and a multiple of LANES.
- LANES, 1, serial output width per beat; BEATS = WIDTH/LANES.
- LSB_FIRST, 0, 0 = most significant lane-group first, 1 = least significant first.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- d_in  input  WIDTH  parallel word
- d_valid  input  1  d_in is valid
- d_ready  output  1  block accepts d_in this cycle
- d_out  output  LANES  serial beat
- out_valid  output  1  d_out is valid
- out_ready  input  1  downstream accepts the beat
- frame_start  output  1  current beat is the first beat of a word
- frame_end  output  1  current beat is the last beat of a word (parity beat if PISO_PARITY_EN)
- busy  output  1  a word is in flight (equals out_valid)

Behaviour:
- One clock (clk); reset is synchronous, active-high. While reset=1 at a rising edge: state←IDLE, shift register←0, beat counter←0.
- Reset values: out_valid=0, d_out=0, frame_start=0, frame_end=0, busy=0. d_ready is forced to 0 while reset is high.
- States:
  - IDLE: d_ready=1, out_valid=0.
  - SHIFT: out_valid=1; counter idx runs 0..BEATS-1.
  - PAR: exists only with PISO_PARITY_EN.
- Accept: on a rising edge with d_valid && d_ready, d_in is loaded into the shift register, idx←0, state←SHIFT.
  - The first beat appears on d_out the cycle after acceptance (latency 1).
- Beat selection: beat k = d_in[WIDTH-1-k*LANES -: LANES] when LSB_FIRST=0; d_in[k*LANES +: LANES] when LSB_FIRST=1.
- Advance: a beat completes on an edge with out_valid && out_ready. With out_ready=0, d_out, idx and all flags hold unchanged.
- Flags:
  - frame_start = out_valid && idx==0.
  - frame_end = out_valid && idx==BEATS-1 (non-parity build).
- d_ready = IDLE || (SHIFT && idx==BEATS-1 && out_ready) (non-parity build).
- Completion of the last beat:
  - If a new word is accepted on the same edge: reload, idx←0, stay in SHIFT. No bubble between words.
  - Otherwise: state←IDLE; out_valid drops the next cycle.
- d_valid while d_ready=0 is ignored; the source must hold the word.
- Reset mid-frame aborts the word immediately. No further beats, and no frame_end for the aborted word.
- A pending d_valid during reset is not accepted.
- All outputs are registered except d_ready, which is combinational from state, idx and out_ready.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After beat BEATS-1 completes, the block enters PAR for one extra beat.
  - In PAR: d_out[0] = XOR of all WIDTH bits (even parity); other lanes = 0.
  - frame_end asserts on the PAR beat only.
  - d_ready = IDLE || (PAR && out_ready); back-to-back loading occurs from PAR.
  - A frame is BEATS+1 beats.
- Undefined: no PAR state, no parity logic; behaviour exactly as above.

Decomposition:
- Package piso_pkg:
  - State enum: IDLE, SHIFT, PAR.
  - Function beats_f(WIDTH, LANES).
  - Function clog2-based counter width.
- One natural sub-module, piso_beat_mux: combinational selection of beat idx from the shift register per LSB_FIRST.
- The top level holds the FSM, counter, handshake and parity logic.

Test Plan:
- WIDTH=4, LANES=1, LSB_FIRST=0, out_ready=1; load 4'b1001 → d_out 1,0,0,1 on cycles 1–4; frame_start on cycle 1, frame_end on cycle 4; out_valid=0 on cycle 5.
- Same configuration with LSB_FIRST=1; load 4'b1010 → d_out 0,1,0,1.
- Back-to-back: load 4'b1001, then 4'b1111 held valid → 8 contiguous beats 1,0,0,1,1,1,1,1; d_ready high only on cycles 0 and 4; out_valid never drops between words.
- Backpressure: load 4'b1001; out_ready=0 for 3 cycles during beat 2 → d_out holds 0 and idx holds; the sequence resumes with 0,1; total 7 cycles.
- WIDTH=8, LANES=2: load 8'hA5 → beats 2'b10, 2'b10, 2'b01, 2'b01. Reset asserted during beat 2 → next cycle out_valid=0, d_out=0, no frame_end.
- With PISO_PARITY_EN, WIDTH=4: load 4'b1011 → d_out 1,0,1,1, then parity beat 1; frame_end only on beat 5.
